// File: rtl/sevseg_pkg.sv
// sevseg_pkg -- shared definitions for the seven-segment capture block.
//   * Active-low segment codes {g,f,e,d,c,b,a} for hex digits 0..F and the dash.
//   * FSM state enum used by sevseg_capture.
//   * Small anode helpers: exactly-one-low test and position of the low bit.
package sevseg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // True when exactly one active-low anode is asserted.
  function automatic logic one_low(input logic [3:0] an_v);
    case (an_v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  // Index of the asserted anode; only meaningful when one_low() holds.
  function automatic logic [1:0] low_pos(input logic [3:0] an_v);
    case (an_v)
      4'b1101: low_pos = 2'd1;
      4'b1011: low_pos = 2'd2;
      4'b0111: low_pos = 2'd3;
      default: low_pos = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// sevseg_decode -- combinational active-low segment pattern to hex lookup.
// Ports:
//   seg_i   [6:0] segment lines {g,f,e,d,c,b,a}, active low
//   hit_o         pattern is one of the 16 hex glyphs
//   value_o [3:0] decoded value (0 on a miss)
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] value_o
);

  // Glyph table lookup; anything else (dash included) is a miss.
  always_comb begin
    hit_o   = 1'b1;
    value_o = 4'h0;
    case (seg_i)
      SEG_0:   value_o = 4'h0;
      SEG_1:   value_o = 4'h1;
      SEG_2:   value_o = 4'h2;
      SEG_3:   value_o = 4'h3;
      SEG_4:   value_o = 4'h4;
      SEG_5:   value_o = 4'h5;
      SEG_6:   value_o = 4'h6;
      SEG_7:   value_o = 4'h7;
      SEG_8:   value_o = 4'h8;
      SEG_9:   value_o = 4'h9;
      SEG_A:   value_o = 4'hA;
      SEG_B:   value_o = 4'hB;
      SEG_C:   value_o = 4'hC;
      SEG_D:   value_o = 4'hD;
      SEG_E:   value_o = 4'hE;
      SEG_F:   value_o = 4'hF;
      default: hit_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevseg_capture.sv
// sevseg_capture -- snoops a multiplexed 4-digit seven-segment bus and
// recovers the displayed hex digits.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   an[3:0]               anode enables, active low (an[0] = rightmost)
//   seg[6:0], dp          segments {g,f,e,d,c,b,a} active low; dp ignored
//   digit0..digit3 [3:0]  last captured value per position
//   dvalid[3:0]           position holds a decoded value
//   frame_done            pulse once all four positions captured
//   decode_err            pulse on unknown glyph or multiple anodes low
//   blank                 display seen fully off for BLANK_CYCLES samples
// Optional feature: define SEVSEG_CAPTURE_BLANK_DETECT_EN to build the blank
// detector; otherwise blank is tied low.
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dvalid,
  output logic       frame_done,
  output logic       decode_err,
  output logic       blank
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [3:0] an_meta_q, an_sync_q, an_prev_q;
  logic [6:0] seg_meta_q, seg_sync_q, seg_prev_q;
  logic [7:0] cnt_q, cnt_d;
  state_e     state_q;
  logic       multi_flag_q;
  logic [3:0] digit_q [4];
  logic [3:0] dvalid_q, mask_q, mask_d_base, sel_bit_d;
  logic       frame_done_q, decode_err_q;
  logic       chg_d, an_chg_d, one_low_d, multi_d, hit_d;
  logic [1:0] pos_d;
  logic [3:0] value_d;
  logic       dp_unused;

  assign dp_unused = dp;

  sevseg_decode u_decode (
    .seg_i   (seg_sync_q),
    .hit_o   (hit_d),
    .value_o (value_d)
  );

  // Change detection, stability counter next value and mask housekeeping.
  always_comb begin
    an_chg_d    = (an_sync_q != an_prev_q);
    chg_d       = an_chg_d || (seg_sync_q != seg_prev_q);
    one_low_d   = one_low(an_sync_q);
    multi_d     = !one_low_d && (an_sync_q != 4'b1111);
    pos_d       = low_pos(an_sync_q);
    sel_bit_d   = 4'b0001 << pos_d;
    cnt_d       = chg_d ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);
    // A full mask is consumed (cleared) on the cycle frame_done is raised.
    mask_d_base = (mask_q == 4'b1111) ? 4'b0000 : mask_q;
  end

  // Two-flop synchronisers, previous-sample register and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta_q  <= 4'b1111;
      an_sync_q  <= 4'b1111;
      an_prev_q  <= 4'b1111;
      seg_meta_q <= 7'b1111111;
      seg_sync_q <= 7'b1111111;
      seg_prev_q <= 7'b1111111;
      cnt_q      <= 8'd0;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      an_prev_q  <= an_sync_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
      cnt_q      <= cnt_d;
    end
  end

  // Capture FSM with registered digit, flag and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_SEL;
      multi_flag_q <= 1'b0;
      digit_q      <= '{default: 4'h0};
      dvalid_q     <= 4'b0000;
      mask_q       <= 4'b0000;
      frame_done_q <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      decode_err_q <= 1'b0;
      frame_done_q <= (mask_q == 4'b1111);
      mask_q       <= mask_d_base;
      if (chg_d) begin
        multi_flag_q <= 1'b0;
      end
      case (state_q)
        WAIT_SEL: begin
          if (one_low_d) begin
            state_q <= SETTLE;
          end else if (multi_d && !chg_d && (cnt_q == CNT_MAX) && !multi_flag_q) begin
            // Report a stable multi-anode pattern once per stable window.
            decode_err_q <= 1'b1;
            multi_flag_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (chg_d) begin
            state_q <= WAIT_SEL;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HOLD;
            if (hit_d) begin
              digit_q[pos_d]  <= value_d;
              dvalid_q[pos_d] <= 1'b1;
              mask_q          <= mask_d_base | sel_bit_d;
            end else begin
              decode_err_q    <= 1'b1;
              dvalid_q[pos_d] <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (an_chg_d) begin
            state_q <= WAIT_SEL;
          end else if (chg_d) begin
            state_q <= SETTLE;
          end
        end
        default: state_q <= WAIT_SEL;
      endcase
    end
  end

  assign digit0     = digit_q[0];
  assign digit1     = digit_q[1];
  assign digit2     = digit_q[2];
  assign digit3     = digit_q[3];
  assign dvalid     = dvalid_q;
  assign frame_done = frame_done_q;
  assign decode_err = decode_err_q;

`ifdef SEVSEG_CAPTURE_BLANK_DETECT_EN
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYCLES - 1);

  logic [15:0] blank_cnt_q;
  logic        blank_q;
  logic        cap_hit_d;

  assign cap_hit_d = (state_q == SETTLE) && !chg_d && (cnt_q == CNT_MAX) && hit_d;

  // Saturating run-length of all-off anode samples; a good capture un-blanks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt_q <= 16'd0;
      blank_q     <= 1'b0;
    end else begin
      if (an_sync_q == 4'b1111) begin
        if (blank_cnt_q != 16'hFFFF) begin
          blank_cnt_q <= blank_cnt_q + 16'd1;
        end
        if (blank_cnt_q >= BLANK_LIM) begin
          blank_q <= 1'b1;
        end
      end else begin
        blank_cnt_q <= 16'd0;
        if (cap_hit_d) begin
          blank_q <= 1'b0;
        end
      end
    end
  end

  assign blank = blank_q;
`else
  localparam int unsigned BLANK_CYCLES_UNUSED = BLANK_CYCLES;
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_sevseg_capture.sv
// Scoreboard bench for sevseg_capture: each held {an,seg} segment is turned
// into an expected event (digit load, glyph error, multi-anode error) due
// 2 + STABLE_CYCLES + 1 cycles after the change when held long enough; a
// monitor applies due events to an output model and compares every cycle.
`timescale 1ns/1ps
module tb_sevseg_capture;

  localparam int S   = 4;
  localparam int LAT = S + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an  = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic       dp  = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3, dvalid;
  logic       frame_done, decode_err, blank;

  sevseg_capture #(.STABLE_CYCLES(S), .BLANK_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dvalid(dvalid), .frame_done(frame_done), .decode_err(decode_err),
    .blank(blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int kind;  // 0 = digit hit, 1 = glyph miss, 2 = multi-anode
    int pos;
    int val;
  } ev_t;

  ev_t q[$];

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] DASH = 7'b0111111;

  int  tests  = 0;
  int  fails  = 0;
  bit  mon_en = 1'b0;

  logic [3:0] exp_dig [4];
  logic [3:0] exp_dv, mask;
  logic       exp_fd, exp_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (tab[i] == s) return i;
    return -1;
  endfunction

  function automatic int low_pos(input logic [3:0] a);
    int n = 0;
    int p = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  // Drive one segment and schedule the event it must produce, if any.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int len);
    ev_t e;
    int  p, v;
    an  = a;
    seg = s;
    dp  = 1'($urandom_range(0, 1));
    if (len >= S + 1 && a != 4'hF) begin
      e.due = cyc + LAT;
      e.pos = 0;
      e.val = 0;
      p = low_pos(a);
      if (p < 0) begin
        e.kind = 2;
      end else begin
        v = lookup(s);
        e.pos  = p;
        e.kind = (v < 0) ? 1 : 0;
        e.val  = (v < 0) ? 0 : v;
      end
      q.push_back(e);
    end
    repeat (len) begin @(posedge clk); #1; end
  endtask

  // Monitor: apply due events to the output model and compare each cycle.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) exp_dig[i] = 4'h0;
        exp_dv  = 4'h0;
        mask    = 4'h0;
        exp_fd  = 1'b0;
        exp_err = 1'b0;
      end else begin
        exp_fd = (mask == 4'hF);
        if (exp_fd) mask = 4'h0;
        exp_err = 1'b0;
        while (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          if (e.due != cyc) check("event_time", e.due, cyc);
          case (e.kind)
            0: begin
              exp_dig[e.pos] = e.val[3:0];
              exp_dv[e.pos]  = 1'b1;
              mask[e.pos]    = 1'b1;
            end
            1: begin
              exp_err       = 1'b1;
              exp_dv[e.pos] = 1'b0;
            end
            default: exp_err = 1'b1;
          endcase
        end
      end
      if (mon_en) begin
        check("outputs", {digit3, digit2, digit1, digit0, dvalid, frame_done, decode_err},
              {exp_dig[3], exp_dig[2], exp_dig[1], exp_dig[0], exp_dv, exp_fd, exp_err});
`ifndef SEVSEG_CAPTURE_BLANK_DETECT_EN
        check("blank_tied", blank, 1'b0);
`endif
      end
    end
  end

  // Stimulus: directed scenarios, randomized segments, blank phase, drain.
  initial begin : driver
    logic [3:0] a;
    logic [6:0] s;
    int         r;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hold(4'hF, 7'h7F, 3);

    hold(4'b1110, tab[2], 10);            // digit0 = 2 after 7 cycles
    hold(4'b1110, DASH, 8);               // dash: error, dvalid[0] clears
    hold(4'b1110, tab[1], 8);             // full frame 1,2,3,4
    hold(4'b1101, tab[2], 8);
    hold(4'b1011, tab[3], 8);
    hold(4'b0111, tab[4], 8);
    for (int i = 0; i < 10; i++)          // toggling faster than the window
      hold(4'b1110, (i % 2 == 0) ? tab[6] : tab[9], 3);
    hold(4'b1100, tab[5], 8);             // two anodes low

    hold(4'b1110, tab[5], 4);             // reset while settling
    rst = 1'b1;
    q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    hold(4'b1110, tab[5], 10);

    for (int k = 0; k < 150; k++) begin
      do begin
        r = $urandom_range(0, 9);
        a = 4'(~(4'b0001 << $urandom_range(0, 3)));
        if (r < 6) begin
          s = tab[$urandom_range(0, 15)];
        end else if (r < 8) begin
          s = (r == 6) ? DASH : 7'($urandom_range(0, 127));
        end else if (r == 8) begin
          s = 7'($urandom_range(0, 127));
          do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
        end else begin
          a = 4'hF;
          s = 7'($urandom_range(0, 127));
        end
      end while ({a, s} == {an, seg});
      hold(a, s, $urandom_range(1, 12));
    end

    hold(4'hF, 7'h7F, 1100);
`ifdef SEVSEG_CAPTURE_BLANK_DETECT_EN
    check("blank_set", blank, 1'b1);
`endif
    hold(4'b1110, tab[3], 10);
`ifdef SEVSEG_CAPTURE_BLANK_DETECT_EN
    check("blank_clear", blank, 1'b0);
`endif
    hold(4'hF, 7'h7F, LAT + 3);
    check("queue_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
